// File: rtl/phase_accumulator.sv
// NCO phase source: advances an ACC_W-bit accumulator by a tuning word per sample tick.
// Optional tuning-word glide is compiled in with `define PHASE_ACC_GLIDE_EN.
module phase_accumulator #(
  parameter int ACC_W       = 24,
  parameter int PHASE_W     = 8,
  parameter int GLIDE_SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic [ACC_W-1:0]   tw_data,
  input  logic               tw_valid,
  output logic               tw_ready,
  input  logic               sync,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap,
  output logic [1:0]         dbg_state,
  output logic [ACC_W-1:0]   dbg_active_tw
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GLIDE = 2'd2
  } state_t;

  state_t               state_q;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     active_q;
  logic [ACC_W-1:0]     pend_tw_q;
  logic                 pend_q;
  logic [PHASE_W-1:0]   phase_q;
  logic                 pv_q;
  logic                 wrap_q;

  logic                 accept;
  logic                 apply;
  logic [ACC_W:0]       sum;

  // Handshake: a word transfers when tw_valid && tw_ready; tw_ready is low while a
  // word waits in the pending slot, which empties on the next sample_tick.
  assign tw_ready = !pend_q;
  assign accept   = tw_valid && !pend_q;
  assign apply    = sample_tick && pend_q;
  assign sum      = {1'b0, acc_q} + {1'b0, active_q};

  assign phase         = phase_q;
  assign phase_valid   = pv_q;
  assign wrap          = wrap_q;
  assign dbg_state     = state_q;
  assign dbg_active_tw = active_q;

  // Slew step toward tgt: |diff| >> GLIDE_SHIFT, at least 1, never past tgt.
  function automatic logic [ACC_W-1:0] glide_next(input logic [ACC_W-1:0] cur,
                                                  input logic [ACC_W-1:0] tgt);
    logic [ACC_W-1:0] diff;
    logic [ACC_W-1:0] step;
    diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
    step = diff >> GLIDE_SHIFT;
    if (step == '0) step = {{(ACC_W-1){1'b0}}, 1'b1};
    if (step >= diff)   return tgt;
    else if (tgt > cur) return cur + step;
    else                return cur - step;
  endfunction

`ifdef PHASE_ACC_GLIDE_EN
  logic [ACC_W-1:0] target_q;
  logic [ACC_W-1:0] glide_nxt;
  assign glide_nxt = glide_next(active_q, target_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      active_q  <= '0;
      pend_tw_q <= '0;
      pend_q    <= 1'b0;
      phase_q   <= '0;
      pv_q      <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef PHASE_ACC_GLIDE_EN
      target_q  <= '0;
`endif
    end else begin
      pv_q   <= 1'b0;
      wrap_q <= 1'b0;

      if (accept) begin
        pend_q    <= 1'b1;
        pend_tw_q <= tw_data;
      end else if (apply) begin
        pend_q <= 1'b0;
      end

      if (state_q == S_IDLE) begin
        if (sync) acc_q <= '0;
        // First word out of IDLE loads directly; that tick does not advance acc.
        if (apply && pend_tw_q != '0) begin
          active_q <= pend_tw_q;
          state_q  <= S_RUN;
`ifdef PHASE_ACC_GLIDE_EN
          target_q <= pend_tw_q;
`endif
        end
      end else begin
        if (sync) begin
          acc_q   <= '0;
          phase_q <= '0;
          pv_q    <= 1'b1;
          wrap_q  <= 1'b1;
`ifdef PHASE_ACC_GLIDE_EN
        end else if (sample_tick) begin
`else
        // A zero word stops the oscillator on its applying tick with acc frozen.
        end else if (sample_tick && !(apply && pend_tw_q == '0)) begin
`endif
          acc_q   <= sum[ACC_W-1:0];
          phase_q <= sum[ACC_W-1 -: PHASE_W];
          pv_q    <= 1'b1;
          wrap_q  <= sum[ACC_W];
        end

`ifdef PHASE_ACC_GLIDE_EN
        if (apply) begin
          target_q <= pend_tw_q;
          state_q  <= S_GLIDE;
        end else if (state_q == S_GLIDE && sample_tick && !sync) begin
          active_q <= glide_nxt;
          if (glide_nxt == target_q) state_q <= (target_q == '0) ? S_IDLE : S_RUN;
        end
`else
        if (apply) begin
          active_q <= pend_tw_q;
          state_q  <= (pend_tw_q == '0) ? S_IDLE : S_RUN;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: spec-level model checked every cycle
// plus directed literal expectations.
module tb_phase_accumulator;

  localparam int ACC_W   = 24;
  localparam int PHASE_W = 8;
  localparam int GS      = 6;
  localparam longint MOD = 64'h1000000;
`ifdef PHASE_ACC_GLIDE_EN
  localparam bit GLIDE = 1'b1;
`else
  localparam bit GLIDE = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               sample_tick = 1'b0;
  logic [ACC_W-1:0]   tw_data = '0;
  logic               tw_valid = 1'b0;
  logic               tw_ready;
  logic               sync = 1'b0;
  logic [PHASE_W-1:0] phase;
  logic               phase_valid;
  logic               wrap;
  logic [1:0]         dbg_state;
  logic [ACC_W-1:0]   dbg_active_tw;

  int n_cmp  = 0;
  int n_fail = 0;

  phase_accumulator #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .GLIDE_SHIFT(GS)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .tw_data(tw_data),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .sync(sync), .phase(phase),
    .phase_valid(phase_valid), .wrap(wrap), .dbg_state(dbg_state),
    .dbg_active_tw(dbg_active_tw)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_acc = 0, m_active = 0, m_pw = 0, m_target = 0;
  bit     m_pend = 0, m_on = 0, m_glide = 0;
  logic [7:0] e_phase = '0;
  bit     e_pv = 0, e_wrap = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_active = 0; m_pw = 0; m_target = 0;
      m_pend = 0; m_on = 0; m_glide = 0;
      e_phase = '0; e_pv = 0; e_wrap = 0;
    end else begin
      bit     app;
      longint s, d, st;
      app    = sample_tick && m_pend;
      e_pv   = 0;
      e_wrap = 0;
      if (!m_on) begin
        if (sync) m_acc = 0;
        if (app && m_pw != 0) begin
          m_active = m_pw; m_target = m_pw; m_on = 1; m_glide = 0;
        end
      end else begin
        if (sync) begin
          m_acc = 0; e_phase = 8'h00; e_pv = 1; e_wrap = 1;
        end else if (sample_tick && !(!GLIDE && app && m_pw == 0)) begin
          s      = m_acc + m_active;
          e_wrap = (s >= MOD);
          m_acc  = s % MOD;
          e_phase = m_acc[23:16];
          e_pv   = 1;
        end
        if (app) begin
          if (GLIDE) begin
            m_target = m_pw; m_glide = 1;
          end else begin
            m_active = m_pw; m_on = (m_pw != 0);
          end
        end else if (m_glide && sample_tick && !sync) begin
          d  = (m_target > m_active) ? m_target - m_active : m_active - m_target;
          st = d >> GS;
          if (st < 1) st = 1;
          if (st >= d) m_active = m_target;
          else if (m_target > m_active) m_active = m_active + st;
          else m_active = m_active - st;
          if (m_active == m_target) begin
            m_glide = 0; m_on = (m_target != 0);
          end
        end
      end
      if (app) m_pend = 0;
      else if (tw_valid && !m_pend) begin
        m_pend = 1; m_pw = longint'(tw_data);
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    chk("model_phase",       phase,         e_phase);
    chk("model_phase_valid", phase_valid,   e_pv);
    chk("model_wrap",        wrap,          e_wrap);
    chk("model_tw_ready",    tw_ready,      !m_pend);
    chk("model_active_tw",   dbg_active_tw, m_active[23:0]);
  end

  // ---------------- driver ----------------
  task automatic step(input bit t, input bit s, input bit v, input logic [ACC_W-1:0] d);
    sample_tick = t; sync = s; tw_valid = v; tw_data = d;
    @(negedge clk);
    sample_tick = 0; sync = 0; tw_valid = 0; tw_data = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [ACC_W-1:0] prev;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_phase", phase, 8'h00);
    chk("reset_pv", phase_valid, 1'b0);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_ready", tw_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ramp with 0x010000
    step(0, 0, 1, 24'h010000);
    chk("accept_ready_low", tw_ready, 1'b0);
    step(1, 0, 0, '0);
    chk("idle_load_no_pv", phase_valid, 1'b0);
    chk("ready_after_tick", tw_ready, 1'b1);
    for (int k = 1; k <= 256; k++) begin
      step(1, 0, 0, '0);
      if (k == 1)   chk("ramp_1", phase, 8'h01);
      if (k == 2)   chk("ramp_2", phase, 8'h02);
      if (k == 255) chk("ramp_255_nowrap", {phase, wrap}, {8'hFF, 1'b0});
      if (k == 256) chk("ramp_256_wrap", {phase, wrap, phase_valid}, {8'h00, 1'b1, 1'b1});
    end
    repeat (8'h5A) step(1, 0, 0, '0);
    chk("at_5a", phase, 8'h5A);

    // Sync together with a tick
    step(1, 1, 0, '0);
    chk("sync_phase", {phase, phase_valid, wrap}, {8'h00, 1'b1, 1'b1});
    step(1, 0, 0, '0);
    chk("after_sync", {phase, wrap}, {8'h01, 1'b0});

    // Word offered on a tick: old word used; second offer refused
    step(1, 0, 1, 24'h800000);
    chk("same_tick_old_word", phase, 8'h02);
    chk("ready_low_after_accept", tw_ready, 1'b0);
    step(1, 0, 1, 24'h123456);
    chk("apply_tick_ready_up", tw_ready, 1'b1);
`ifndef PHASE_ACC_GLIDE_EN
    chk("apply_tick_old_incr", phase, 8'h03);
    step(1, 0, 0, '0);
    chk("new_word_83", {phase, wrap}, {8'h83, 1'b0});
    step(1, 0, 0, '0);
    chk("new_word_03_wrap", {phase, wrap}, {8'h03, 1'b1});

    // Zero word stops the oscillator
    step(0, 0, 1, '0);
    step(1, 0, 0, '0);
    chk("zero_no_pv", {phase_valid, phase}, {1'b0, 8'h03});
    chk("zero_active", dbg_active_tw, 24'h0);
    step(1, 0, 0, '0);
    chk("zero_still_no_pv", phase_valid, 1'b0);
`else
    step(0, 0, 1, '0);
    for (int i = 0; i < 3000 && !(dbg_state == 2'd0 && tw_ready); i++) step(1, 0, 0, '0);
    chk("glide_to_zero_idle", dbg_state, 2'd0);
`endif

    // Sync in IDLE: no strobes
    step(0, 1, 0, '0);
    chk("idle_sync_no_pv", {phase_valid, wrap}, 2'b00);

    // Half-scale word alternates 0x80 / 0x00
    step(0, 0, 1, 24'h800000);
    step(1, 0, 0, '0);
    chk("half_load_no_pv", phase_valid, 1'b0);
    step(1, 0, 0, '0);
    chk("half_80", {phase, wrap}, {8'h80, 1'b0});
    step(1, 0, 0, '0);
    chk("half_00_wrap", {phase, wrap}, {8'h00, 1'b1});
    step(1, 0, 0, '0);
    chk("half_80_again", {phase, wrap}, {8'h80, 1'b0});

    // Reset mid-run with a word pending
    step(0, 0, 1, 24'h400000);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {phase, phase_valid, wrap}, {8'h00, 1'b0, 1'b0});
    chk("midreset_ready", tw_ready, 1'b1);
    chk("midreset_active", dbg_active_tw, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tuning-word change 0x010000 -> 0x020000
    step(0, 0, 1, 24'h010000);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(0, 0, 1, 24'h020000);
    step(1, 0, 0, '0);
`ifdef PHASE_ACC_GLIDE_EN
    prev = dbg_active_tw;
    for (int i = 0; i < 3000 && dbg_state != 2'd1; i++) begin
      step(1, 0, 0, '0);
      chk("glide_monotonic", dbg_active_tw >= prev, 1'b1);
      chk("glide_no_overshoot", dbg_active_tw <= 24'h020000, 1'b1);
      prev = dbg_active_tw;
    end
    chk("glide_back_to_run", dbg_state, 2'd1);
    chk("glide_final_tw", dbg_active_tw, 24'h020000);
`else
    prev = dbg_active_tw;
    chk("step_immediate", prev, 24'h020000);
    step(1, 0, 0, '0);
    chk("step_phase_05", phase, 8'h05);
`endif

    repeat (2) step(0, 0, 0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_accumulator.md
# phase_accumulator

Numerically controlled phase source for the synth voice path. It advances a wide accumulator by a tuning word on each sample tick and presents the top bits as the 8-bit phase index consumed by the wave generators (triangle, etc.). It also provides a valid/ready tuning-word interface, hard sync, and a wrap pulse for downstream envelope and oscillator sync.

## Interface
- ACC_W, 24, accumulator and tuning-word width
- PHASE_W, 8, phase output width (top PHASE_W bits of accumulator)
- GLIDE_SHIFT, 6, glide slew divisor exponent (used only with glide compiled in)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sample_tick  in  1  one-cycle pulse at sample rate
- tw_data  in  ACC_W  tuning word (phase increment per tick)
- tw_valid  in  1  tuning word offered
- tw_ready  out  1  block can accept a tuning word
- sync  in  1  hard sync request
- phase  out  PHASE_W  acc[ACC_W-1 -: PHASE_W], registered
- phase_valid  out  1  one-cycle strobe: phase updated
- wrap  out  1  one-cycle strobe with phase_valid: accumulator overflowed or was synced

## Operation
- Registers: acc, active_tw, pending_tw, pending flag, state (IDLE, RUN, GLIDE).
- Handshake: transfer when tw_valid && tw_ready. Word goes to pending_tw; tw_ready = !pending. Pending word is applied at the next sample_tick, then pending clears.
- A word accepted in the same cycle as sample_tick is not applied on that tick; that tick uses the old active_tw.
- IDLE (after reset): acc held, no phase_valid. A pending word != 0 applied at a tick loads active_tw and moves to RUN. That tick performs no increment.
- RUN, on tick: acc <= acc + active_tw mod 2^ACC_W. wrap = carry out. phase_valid = 1.
- Applied word == 0: active_tw <= 0, state -> IDLE, acc holds.
- Sync, in any cycle, RUN or GLIDE: acc <= 0, phase <= 0, phase_valid <= 1, wrap <= 1. Sync wins over a simultaneous tick; the increment is discarded, but a pending word is still applied.
- Sync in IDLE: acc <= 0, no strobes.
- Arithmetic is unsigned. Overflow wraps silently; carry goes to wrap only.

## Timing
- Reset values: acc 0, phase 0, phase_valid 0, wrap 0, tw_ready 1, active_tw 0, state IDLE.
- Latency: phase/phase_valid/wrap are valid in the cycle after the tick (or sync). Strobes last exactly one cycle.
- tw_ready drops in the cycle after acceptance and rises in the cycle after the applying tick.
- Back-to-back ticks (tick every cycle) are supported at full rate.
- Reset asserted mid-operation immediately forces all reset values. A pending word is discarded.

## Configuration
- PHASE_ACC_GLIDE_EN defined: a word applied in RUN or GLIDE becomes target_tw, and state -> GLIDE.
  - Each tick, the increment uses the current active_tw. active_tw then moves toward target by max(|target-active_tw| >> GLIDE_SHIFT, 1), clamped to target with no overshoot.
  - On reaching target: state -> RUN, or -> IDLE if target is 0.
  - A new word during GLIDE replaces target without resetting active_tw.
  - The first word from IDLE is applied immediately, with no glide.
- PHASE_ACC_GLIDE_EN undefined: the GLIDE state and target register are absent. Words apply instantly at the tick. GLIDE_SHIFT is ignored.

## Test plan
- Reset, then tw 0x010000 accepted, then ticks: phase reads 0x00,0x01,…; wrap=1 exactly when phase returns to 0x00 after 256 increments.
- tw 0x800000: phase alternates 0x80, 0x00, with wrap=1 on every 0x00 strobe.
- tw_valid in the same cycle as sample_tick: that tick uses the old word. tw_ready is low until the cycle after the next tick. A second tw_valid while not ready is not accepted.
- sync with tick in the same cycle at phase 0x5A: next cycle phase 0x00, wrap=1, phase_valid=1. The following tick gives phase = tw top bits.
- Apply tw 0 in RUN: no further phase_valid, phase holds. Reassert rst_n low mid-run: all outputs 0, tw_ready 1 immediately.
- With PHASE_ACC_GLIDE_EN: 0x010000 -> 0x020000. active_tw rises monotonically, reaches exactly 0x020000, never overshoots, and the state returns to RUN. Without the macro, the step is immediate.
